alu_sequencer: RTL and testbench

Command-side initiator for the 8-bit accumulator ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's input-mux selector, operands and one-hot output selector. It waits out the ALU's registered input stage, captures the result and overflow flag, and returns them over a second valid/ready handshake. It sits between the control logic and the ALU, replacing hand-driven selector lines.

---
 rtl/alu_sequencer_if.sv | 24 ++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command and response handshake bundle between control logic and the ALU sequencer.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_overflow;
  logic       rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_overflow, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_overflow, rsp_error
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command at a time into the registered-input accumulator ALU and
// returns the sampled result; every output comes straight from a flop.
module alu_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus,
  output logic [2:0]     alu_in_selector,
  output logic [7:0]     alu_num1,
  output logic [7:0]     alu_num2,
  output logic [6:0]     alu_out_selector,
  input  logic [7:0]     alu_result,
  input  logic           alu_overflow,
  output logic [15:0]    cmd_count
);
  localparam int CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [2:0] SEL_RESET = 3'b001;
  localparam logic [2:0] SEL_LOAD  = 3'b010;
  localparam logic [2:0] OP_MULT   = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [7:0]       last_result, last_nxt;
  logic             cmd_ready_q, cmd_ready_nxt;
  logic             rsp_valid_q, rsp_valid_nxt;
  logic [7:0]       rsp_data_q, rsp_data_nxt;
  logic             rsp_ovf_q, rsp_ovf_nxt;
  logic             rsp_err_q, rsp_err_nxt;
  logic [2:0]       in_sel_nxt;
  logic [7:0]       num1_nxt, num2_nxt;
  logic [6:0]       out_sel_nxt;
  logic [15:0]      count_nxt;
  logic             accept, last_wait;

  assign accept    = (state == IDLE) && bus.cmd_valid && cmd_ready_q;
  assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_error    = rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      op_q             <= '0;
      last_result      <= '0;
      cmd_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_ovf_q        <= 1'b0;
      rsp_err_q        <= 1'b0;
      alu_in_selector  <= SEL_RESET;
      alu_num1         <= '0;
      alu_num2         <= '0;
      alu_out_selector <= '0;
      cmd_count        <= '0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      op_q             <= op_nxt;
      last_result      <= last_nxt;
      cmd_ready_q      <= cmd_ready_nxt;
      rsp_valid_q      <= rsp_valid_nxt;
      rsp_data_q       <= rsp_data_nxt;
      rsp_ovf_q        <= rsp_ovf_nxt;
      rsp_err_q        <= rsp_err_nxt;
      alu_in_selector  <= in_sel_nxt;
      alu_num1         <= num1_nxt;
      alu_num2         <= num2_nxt;
      alu_out_selector <= out_sel_nxt;
      cmd_count        <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (bus.cmd_op == OP_ILLEGAL) ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (last_wait) state_nxt = RESP;
      RESP:  if (rsp_valid_q && bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; anything not named here holds.
  always_comb begin
    cnt_nxt       = cnt;
    op_nxt        = op_q;
    last_nxt      = last_result;
    cmd_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = rsp_valid_q;
    rsp_data_nxt  = rsp_data_q;
    rsp_ovf_nxt   = rsp_ovf_q;
    rsp_err_nxt   = rsp_err_q;
    in_sel_nxt    = alu_in_selector;
    num1_nxt      = alu_num1;
    num2_nxt      = alu_num2;
    out_sel_nxt   = alu_out_selector;
    count_nxt     = cmd_count;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt = bus.cmd_op;
          if (bus.cmd_op == OP_ILLEGAL) begin
            rsp_err_nxt  = 1'b1;
            rsp_data_nxt = '0;
            rsp_ovf_nxt  = 1'b0;
          end else begin
            num1_nxt    = bus.cmd_chain ? last_result : bus.cmd_a;
            num2_nxt    = bus.cmd_b;
            in_sel_nxt  = SEL_LOAD;
            out_sel_nxt = 7'b1000000 >> bus.cmd_op;
          end
        end
      end
      ISSUE: cnt_nxt = CNT_W'(ALU_LATENCY);
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (last_wait) begin
          rsp_data_nxt  = alu_result;
          rsp_ovf_nxt   = alu_overflow && (op_q == OP_MULT);
          rsp_err_nxt   = 1'b0;
          last_nxt      = alu_result;
          rsp_valid_nxt = 1'b1;
        end
      end
      RESP: begin
        // Illegal ops enter here with valid still low; raise it one edge later.
        if (!rsp_valid_q) begin
          rsp_valid_nxt = 1'b1;
        end else if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          count_nxt     = cmd_count + 16'd1;
          in_sel_nxt    = SEL_RESET;
          out_sel_nxt   = '0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a small behavioral registered-input ALU.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alu_in_selector;
  logic [7:0]  alu_num1, alu_num2;
  logic [6:0]  alu_out_selector;
  logic [7:0]  alu_result;
  logic        alu_overflow;
  logic [15:0] cmd_count;
  int          vectors = 0;
  int          miscompares = 0;

  alu_sequencer_if bus();

  alu_sequencer #(.ALU_LATENCY(1)) dut (
    .clk              (clk),
    .rst              (rst_n),
    .bus              (bus),
    .alu_in_selector  (alu_in_selector),
    .alu_num1         (alu_num1),
    .alu_num2         (alu_num2),
    .alu_out_selector (alu_out_selector),
    .alu_result       (alu_result),
    .alu_overflow     (alu_overflow),
    .cmd_count        (cmd_count)
  );

  always #5 clk = ~clk;

  // Behavioral ALU: operands registered on load, output muxed combinationally.
  logic [7:0]  r1, r2;
  logic [15:0] prod;
  always @(posedge clk) begin
    if (alu_in_selector == 3'b010) begin
      r1 <= alu_num1;
      r2 <= alu_num2;
    end else if (alu_in_selector == 3'b001) begin
      r1 <= 8'h00;
      r2 <= 8'h00;
    end
  end

  always_comb begin
    prod         = 16'(r1) * 16'(r2);
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    case (alu_out_selector)
      7'b1000000: alu_result = r1 & r2;
      7'b0100000: alu_result = r1 | r2;
      7'b0010000: alu_result = ~r1;
      7'b0001000: alu_result = r1 ^ r2;
      7'b0000100: alu_result = r1 + r2;
      7'b0000010: alu_result = r1 - r2;
      7'b0000001: begin
        alu_result   = prod[7:0];
        alu_overflow = (prod[15:8] != 8'h00);
      end
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic chain, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_chain = chain;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_chain = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_chain = 1'b0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", 16'(bus.cmd_ready), 16'h0);
    chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
    chk("rst_rsp_data", 16'(bus.rsp_data), 16'h00);
    chk("rst_in_sel", 16'(alu_in_selector), 16'b001);
    chk("rst_out_sel", 16'(alu_out_selector), 16'h00);
    chk("rst_num1", 16'(alu_num1), 16'h00);
    chk("rst_count", cmd_count, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 16'(bus.cmd_ready), 16'h1);

    // ADD 0x0F + 0x01 with rsp_ready already high.
    bus.rsp_ready = 1'b1;
    issue(3'd4, 1'b0, 8'h0F, 8'h01);
    chk("add_out_sel", 16'(alu_out_selector), 16'b0000100);
    chk("add_in_sel", 16'(alu_in_selector), 16'b010);
    chk("add_ready_low", 16'(bus.cmd_ready), 16'h0);
    tick();
    chk("add_valid_e1", 16'(bus.rsp_valid), 16'h0);
    tick();
    chk("add_valid_e2", 16'(bus.rsp_valid), 16'h1);
    chk("add_data", 16'(bus.rsp_data), 16'h10);
    chk("add_ovf", 16'(bus.rsp_overflow), 16'h0);
    chk("add_err", 16'(bus.rsp_error), 16'h0);
    tick();
    chk("add_valid_drop", 16'(bus.rsp_valid), 16'h0);
    chk("add_count", cmd_count, 16'd1);
    chk("add_in_sel_back", 16'(alu_in_selector), 16'b001);
    chk("add_out_sel_back", 16'(alu_out_selector), 16'h00);
    chk("add_ready_back", 16'(bus.cmd_ready), 16'h1);

    // MULT 0x10 * 0x10 overflows to 0x00.
    issue(3'd6, 1'b0, 8'h10, 8'h10);
    chk("mult_out_sel", 16'(alu_out_selector), 16'b0000001);
    tick();
    tick();
    chk("mult_valid", 16'(bus.rsp_valid), 16'h1);
    chk("mult_data", 16'(bus.rsp_data), 16'h00);
    chk("mult_ovf", 16'(bus.rsp_overflow), 16'h1);
    tick();

    issue(3'd0, 1'b0, 8'hF0, 8'h3C);
    chk("and_out_sel", 16'(alu_out_selector), 16'b1000000);
    tick();
    tick();
    chk("and_data", 16'(bus.rsp_data), 16'h30);
    chk("and_ovf", 16'(bus.rsp_overflow), 16'h0);
    tick();

    issue(3'd2, 1'b0, 8'h0F, 8'h99);
    chk("not_out_sel", 16'(alu_out_selector), 16'b0010000);
    tick();
    tick();
    chk("not_data", 16'(bus.rsp_data), 16'hF0);
    tick();
    chk("count_4", cmd_count, 16'd4);

    // Chained SUB uses the previous result, not cmd_a.
    issue(3'd4, 1'b0, 8'h05, 8'h03);
    tick();
    tick();
    chk("chain_add_data", 16'(bus.rsp_data), 16'h08);
    tick();
    issue(3'd5, 1'b1, 8'hFF, 8'h02);
    chk("chain_num1", 16'(alu_num1), 16'h08);
    chk("chain_num2", 16'(alu_num2), 16'h02);
    chk("sub_out_sel", 16'(alu_out_selector), 16'b0000010);
    tick();
    tick();
    chk("chain_sub_data", 16'(bus.rsp_data), 16'h06);
    tick();

    // Illegal opcode: no ALU load, error response one edge after accept.
    issue(3'd7, 1'b0, 8'hAA, 8'h55);
    chk("ill_in_sel", 16'(alu_in_selector), 16'b001);
    chk("ill_out_sel", 16'(alu_out_selector), 16'h00);
    chk("ill_err", 16'(bus.rsp_error), 16'h1);
    chk("ill_data", 16'(bus.rsp_data), 16'h00);
    chk("ill_valid_e0", 16'(bus.rsp_valid), 16'h0);
    tick();
    chk("ill_valid_e1", 16'(bus.rsp_valid), 16'h1);
    chk("ill_err_hold", 16'(bus.rsp_error), 16'h1);
    tick();
    chk("ill_count", cmd_count, 16'd7);
    chk("ill_valid_drop", 16'(bus.rsp_valid), 16'h0);

    // Error response leaves the chain value at 0x06.
    issue(3'd4, 1'b1, 8'h00, 8'h01);
    chk("chain2_num1", 16'(alu_num1), 16'h06);
    tick();
    tick();
    chk("chain2_data", 16'(bus.rsp_data), 16'h07);
    chk("chain2_err", 16'(bus.rsp_error), 16'h0);
    tick();

    // Backpressure with stray cmd_valid pulses.
    bus.rsp_ready = 1'b0;
    issue(3'd3, 1'b0, 8'h5A, 8'hFF);
    tick();
    tick();
    chk("bp_valid", 16'(bus.rsp_valid), 16'h1);
    chk("bp_data", 16'(bus.rsp_data), 16'hA5);
    bus.cmd_a  = 8'h11;
    bus.cmd_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = (i % 2 == 0);
      tick();
      chk("bp_hold_valid", 16'(bus.rsp_valid), 16'h1);
      chk("bp_hold_data", 16'(bus.rsp_data), 16'hA5);
      chk("bp_ready_low", 16'(bus.cmd_ready), 16'h0);
    end
    chk("bp_num1_hold", 16'(alu_num1), 16'h5A);
    chk("bp_count_hold", cmd_count, 16'd8);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 16'(bus.rsp_valid), 16'h0);
    chk("bp_release_count", cmd_count, 16'd9);
    tick();
    chk("bp_single_count", cmd_count, 16'd9);
    chk("bp_no_accept", 16'(alu_in_selector), 16'b001);

    // Reset asserted while waiting on the ALU.
    issue(3'd4, 1'b0, 8'h01, 8'h01);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(bus.rsp_valid), 16'h0);
    chk("mid_rst_in_sel", 16'(alu_in_selector), 16'b001);
    chk("mid_rst_num1", 16'(alu_num1), 16'h00);
    chk("mid_rst_count", cmd_count, 16'h0000);
    chk("mid_rst_ready", 16'(bus.cmd_ready), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 16'(bus.cmd_ready), 16'h1);
    chk("post_rst_valid", 16'(bus.rsp_valid), 16'h0);
    tick();
    tick();
    chk("post_rst_no_rsp", 16'(bus.rsp_valid), 16'h0);
    chk("post_rst_count", cmd_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
